// File: rtl/fifo_burst_reader_if.sv
// Bundles the sync_fifo read port and the downstream valid/ready beat stream.
// The reader drives through the master modport; the FIFO and consumer side use slave.
interface fifo_burst_reader_if #(
    parameter int Width = 16
) ();
    logic             fifo_empty;
    logic [Width-1:0] fifo_dout;
    logic             fifo_r_enb;
    logic             out_valid;
    logic             out_ready;
    logic [Width-1:0] out_data;
    logic             out_first;
    logic             out_last;

    modport master (
        input  fifo_empty, fifo_dout, out_ready,
        output fifo_r_enb, out_valid, out_data, out_first, out_last
    );

    modport slave (
        output fifo_empty, fifo_dout, out_ready,
        input  fifo_r_enb, out_valid, out_data, out_first, out_last
    );
endinterface

// File: rtl/fifo_burst_reader.sv
// Drains sync_fifo into a valid/ready stream with first/last burst framing.
// A 2-entry skid buffer absorbs the FIFO's registered read latency.
//   state | meaning
//   IDLE  | no reads issued, buffer empty, busy low
//   RUN   | issuing reads whenever buffer + in-flight word leave room
//   STOP  | no new reads, draining buffered and in-flight words
module fifo_burst_reader #(
    parameter int Width     = 16,
    parameter int BURST_LEN = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    output logic                busy,
    fifo_burst_reader_if.master bus
);
    localparam int CntW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       count_q, count_d;
    logic             inflight_q, inflight_d;
    logic [Width-1:0] buf0_q, buf0_d;
    logic [Width-1:0] buf1_q, buf1_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    logic             valid;
    logic             pop;
    logic             rd;
    logic [1:0]       occ_after_pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            count_q    <= 2'd0;
            inflight_q <= 1'b0;
            buf0_q     <= '0;
            buf1_q     <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (en) state_d = RUN;
            RUN:  if (!en) state_d = STOP;
            STOP: begin
                if (en) begin
                    state_d = RUN;
                end else if (count_q == 2'd0 && !inflight_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        valid = (count_q != 2'd0);
        pop   = valid & bus.out_ready;
        // count + inflight never exceeds 2, so the 2-bit sum cannot wrap
        occ_after_pop = count_q + {1'b0, inflight_q} - {1'b0, pop};
        rd    = (state_q == RUN) & ~bus.fifo_empty & (occ_after_pop < 2'd2);

        inflight_d = rd;
        count_d    = count_q;
        buf0_d     = buf0_q;
        buf1_d     = buf1_q;
        case ({inflight_q, pop})
            2'b10: begin
                if (count_q == 2'd0) begin
                    buf0_d = bus.fifo_dout;
                end else begin
                    buf1_d = bus.fifo_dout;
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                buf0_d  = buf1_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd2) begin
                    buf0_d = buf1_q;
                    buf1_d = bus.fifo_dout;
                end else begin
                    buf0_d = bus.fifo_dout;
                end
            end
            default: begin
            end
        endcase

        cnt_d = cnt_q;
        if (pop) begin
            cnt_d = (cnt_q == CntLast) ? '0 : cnt_q + CntW'(1);
        end
    end

    assign bus.fifo_r_enb = rd;
    assign bus.out_valid  = valid;
    assign bus.out_data   = buf0_q;
    assign bus.out_first  = valid & (cnt_q == '0);
    assign bus.out_last   = valid & (cnt_q == CntLast);
    assign busy           = (state_q != IDLE);
endmodule

// File: tb/tb_fifo_burst_reader.sv
// Scoreboard bench for fifo_burst_reader: a queue-based FIFO model feeds the DUT and an
// occupancy/framing reference model checks every cycle on the falling edge.
module tb_fifo_burst_reader;
    localparam int Width = 16;
    localparam int BL    = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             en = 1'b0;
    logic             busy;
    logic             out_ready = 1'b0;
    logic             fifo_empty_m = 1'b1;
    logic [Width-1:0] fifo_dout_m = '0;

    fifo_burst_reader_if #(.Width(Width)) bus ();

    assign bus.fifo_empty = fifo_empty_m;
    assign bus.fifo_dout  = fifo_dout_m;
    assign bus.out_ready  = out_ready;

    fifo_burst_reader #(.Width(Width), .BURST_LEN(BL)) dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .busy  (busy),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int               n_checks = 0;
    int               n_fail = 0;
    logic [Width-1:0] fq[$];
    logic [Width-1:0] exp_q[$];
    logic             wr_en = 1'b0;
    logic [Width-1:0] wr_data = '0;

    int   occ = 0;
    int   beat_idx = 0;
    int   beats = 0;
    logic prev_rd = 1'b0;
    logic prev_hs = 1'b0;
    logic prev_en = 1'b0;
    logic run_m = 1'b0;
    logic busy_m = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp_v, $time);
        end
    endtask

    // sync_fifo model: registered dout and empty flag, pop requested in the previous cycle
    always @(posedge clk) begin
        if (prev_rd && fq.size() != 0) begin
            fifo_dout_m <= fq.pop_front();
        end
        if (wr_en) begin
            fq.push_back(wr_data);
        end
        fifo_empty_m <= (fq.size() == 0);
    end

    // Reference model: occupancy = words read from the FIFO but not yet accepted downstream
    always @(negedge clk) begin : monitor
        int   occ_pre;
        logic ov_e;
        logic rd_e;
        if (reset) begin
            occ      = 0;
            prev_rd  = 1'b0;
            prev_hs  = 1'b0;
            prev_en  = 1'b0;
            run_m    = 1'b0;
            busy_m   = 1'b0;
            beat_idx = 0;
            while (exp_q.size() > fq.size()) void'(exp_q.pop_front());
        end else begin
            occ_pre = occ;
            busy_m  = prev_en | run_m | (busy_m & (occ_pre != 0));
            run_m   = prev_en;
            occ     = occ_pre + int'(prev_rd) - int'(prev_hs);
            ov_e    = ((occ - int'(prev_rd)) != 0);
            rd_e    = run_m && !bus.fifo_empty && ((occ - int'(ov_e && bus.out_ready)) < 2);

            chk("mon_out_valid", bus.out_valid, ov_e);
            chk("mon_r_enb", bus.fifo_r_enb, rd_e);
            if (bus.fifo_empty) chk("mon_no_read_when_empty", bus.fifo_r_enb, 0);
            chk("mon_busy", busy, busy_m);
            chk("mon_first", bus.out_first, ov_e && (beat_idx % BL == 0));
            chk("mon_last", bus.out_last, ov_e && (beat_idx % BL == BL - 1));
            if (bus.out_valid) begin
                chk("mon_beat_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) chk("mon_data", bus.out_data, exp_q[0]);
            end

            prev_rd = bus.fifo_r_enb;
            prev_hs = bus.out_valid && bus.out_ready;
            prev_en = en;
            if (prev_hs) begin
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                beat_idx++;
                beats++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [Width-1:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        exp_q.push_back(d);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        out_ready = 1'b1;
        for (int i = 0; i < budget && (exp_q.size() != 0 || bus.out_valid); i++) tick();
        chk(name, exp_q.size(), 0);
    endtask

    task automatic wait_valid(input string name, input int budget);
        for (int i = 0; i < budget && !bus.out_valid; i++) tick();
        chk(name, bus.out_valid, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_r_enb"}, bus.fifo_r_enb, 0);
        chk({tag, "_out_valid"}, bus.out_valid, 0);
        chk({tag, "_out_data"}, bus.out_data, 0);
        chk({tag, "_out_first"}, bus.out_first, 0);
        chk({tag, "_out_last"}, bus.out_last, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic rd_tr [16];
        logic ov_tr [16];
        int   ones;
        int   reads;
        int   seen;
        int   b0;

        // T1: asynchronous reset mid-cycle
        #3 reset = 1'b1;
        #1;
        check_reset_outputs("t1");
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // T2: 8 preloaded words streamed with out_ready held high
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) push(16'(i));
        tick();
        en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rd_tr[i] = bus.fifo_r_enb;
            ov_tr[i] = bus.out_valid;
            tick();
        end
        chk("t2_r_enb_first_cycle", rd_tr[0], 0);
        ones = 0;
        for (int i = 1; i <= 8; i++) ones += int'(rd_tr[i]);
        chk("t2_r_enb_run_len", ones, 8);
        chk("t2_r_enb_after_empty", rd_tr[9], 0);
        chk("t2_valid_latency", ov_tr[2], 0);
        ones = 0;
        for (int i = 3; i <= 10; i++) ones += int'(ov_tr[i]);
        chk("t2_no_bubbles", ones, 8);
        chk("t2_valid_after_last", ov_tr[11], 0);
        drain("t2_drain", 20);
        en = 1'b0;
        repeat (3) tick();
        chk("t2_busy_idle", busy, 0);

        // T3: consumer stalls for 5 cycles once the first beat is presented
        out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) push(16'(i));
        en = 1'b1;
        reads = 0;
        for (int i = 0; i < 10 && !bus.out_valid; i++) begin
            reads += int'(bus.fifo_r_enb);
            tick();
        end
        chk("t3_first_valid", bus.out_valid, 1);
        for (int k = 0; k < 5; k++) begin
            reads += int'(bus.fifo_r_enb);
            chk("t3_hold_data", bus.out_data, 16'h0001);
            chk("t3_hold_valid", bus.out_valid, 1);
            tick();
        end
        chk("t3_reads_while_stalled", reads, 2);
        chk("t3_r_enb_full", bus.fifo_r_enb, 0);
        drain("t3_drain", 30);

        // T4: FIFO runs empty between two writes; framing carries across the gap
        b0 = beats;
        for (int i = 1; i <= 3; i++) push(16'h0100 + 16'(i));
        repeat (10) tick();
        chk("t4_gap_valid", bus.out_valid, 0);
        for (int i = 4; i <= 8; i++) push(16'h0100 + 16'(i));
        drain("t4_drain", 30);
        chk("t4_beats", beats - b0, 8);

        // T5: en dropped right after the 2nd read; resume mid-burst
        en = 1'b0;
        repeat (3) tick();
        for (int i = 1; i <= 8; i++) push(16'h0200 + 16'(i));
        en = 1'b1;
        seen = 0;
        for (int i = 0; i < 20 && seen < 2; i++) begin
            if (bus.fifo_r_enb) seen++;
            if (seen < 2) tick();
        end
        en = 1'b0;
        chk("t5_two_reads", seen, 2);
        b0 = beats;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("t5_no_read", bus.fifo_r_enb, 0);
        end
        chk("t5_delivered", beats - b0, 2);
        chk("t5_busy_drained", busy, 0);
        en = 1'b1;
        wait_valid("t5_resume_valid", 10);
        chk("t5_resume_data", bus.out_data, 16'h0203);
        chk("t5_resume_not_first", bus.out_first, 0);
        drain("t5_drain", 30);

        // T6: reset after the 2nd beat of a burst flushes the buffer and restarts framing
        en = 1'b0;
        repeat (3) tick();
        for (int i = 1; i <= 8; i++) push(16'h0300 + 16'(i));
        out_ready = 1'b1;
        en = 1'b1;
        b0 = beats;
        for (int i = 0; i < 20 && (beats - b0) < 2; i++) tick();
        chk("t6_two_beats", beats - b0, 2);
        reset = 1'b1;
        #1;
        check_reset_outputs("t6");
        tick();
        tick();
        reset = 1'b0;
        wait_valid("t6_valid_after_reset", 10);
        chk("t6_first_after_reset", bus.out_first, 1);
        drain("t6_drain", 30);

        // Randomized traffic: writes, backpressure, en toggles and one mid-stream reset
        for (int i = 0; i < 600; i++) begin
            out_ready = ($urandom_range(0, 99) < 70);
            if ($urandom_range(0, 99) < 8) en = ~en;
            if (i == 300) begin
                wr_en = 1'b0;
                reset = 1'b1;
                tick();
                reset = 1'b0;
            end else if (fq.size() < 12 && $urandom_range(0, 99) < 55) begin
                wr_en   = 1'b1;
                wr_data = 16'($urandom);
                exp_q.push_back(wr_data);
            end else begin
                wr_en = 1'b0;
            end
            tick();
        end
        wr_en = 1'b0;
        en    = 1'b1;
        drain("rand_drain", 200);
        chk("rand_fifo_empty", fq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
